// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the packet-aware stream demultiplexer.
package demux_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPkt,
        StDrop
    } demux_state_t;

    localparam int unsigned DROP_CNT_W = 8;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/stream_reg.sv
// One-deep valid/ready register; reloads in the same cycle it drains.
module stream_reg #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             occ_q;
    logic [WIDTH-1:0] data_q;

    assign in_ready_o  = !occ_q || out_ready_i;
    assign out_valid_o = occ_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= 1'b0;
            data_q <= '0;
        end else if (in_valid_i && in_ready_o) begin
            occ_q  <= 1'b1;
            data_q <= in_data_i;
        end else if (out_ready_i) begin
            occ_q  <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// 1:N packet demultiplexer: destination locked on the first beat, invalid selects dropped.
module stream_demux
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N_OUT  = 2,
    localparam int unsigned SEL_W = $clog2(N_OUT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_W-1:0]     s_data_i,
    input  logic [SEL_W-1:0]      s_sel_i,
    input  logic                  s_last_i,
    output logic [N_OUT-1:0]      m_valid_o,
    input  logic [N_OUT-1:0]      m_ready_i,
    output logic [DATA_W-1:0]     m_data_o,
    output logic                  m_last_o,
    output logic                  err_sel_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    demux_state_t          state_q;
    logic [SEL_W-1:0]      dest_q;
    logic                  err_sel_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    logic              sel_ok;
    logic              dest_ready;
    logic              buf_ready;
    logic              buf_valid;
    logic              acc;
    logic              enq;
    logic [DATA_W:0]   buf_out;

    assign sel_ok = 32'(s_sel_i) < N_OUT;

    always_comb begin
        dest_ready = 1'b0;
        m_valid_o  = '0;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            if (32'(dest_q) == i) begin
                dest_ready   = m_ready_i[i];
                m_valid_o[i] = buf_valid;
            end
        end
    end

    // Gated by rst_n so the producer sees no ready while reset is held.
    assign s_ready_o = rst_n && ((state_q == StDrop) || buf_ready);
    assign acc       = s_valid_i && s_ready_o;
    assign enq       = acc && ((state_q == StPkt) || ((state_q == StIdle) && sel_ok));

    stream_reg #(
        .WIDTH (DATA_W + 1)
    ) u_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (enq),
        .in_ready_o  (buf_ready),
        .in_data_i   ({s_last_i, s_data_i}),
        .out_valid_o (buf_valid),
        .out_ready_i (dest_ready),
        .out_data_o  (buf_out)
    );

    assign m_data_o   = buf_out[DATA_W-1:0];
    assign m_last_o   = buf_out[DATA_W];
    assign err_sel_o  = err_sel_q;
    assign drop_cnt_o = drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            dest_q     <= '0;
            err_sel_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            err_sel_q <= acc && (state_q == StIdle) && !sel_ok;
            if (acc) begin
                unique case (state_q)
                    StIdle: begin
                        if (sel_ok) begin
                            dest_q  <= s_sel_i;
                            state_q <= s_last_i ? StIdle : StPkt;
                        end else begin
                            drop_cnt_q <= sat_inc(drop_cnt_q);
                            state_q    <= s_last_i ? StIdle : StDrop;
                        end
                    end
                    StPkt, StDrop: begin
                        if (s_last_i) state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
